// File: rtl/freq_gen.sv
// Square-wave generator: a restoring divider turns freq_hz into a half-period, then a counter toggles wave_out.
// Latency: accept in cycle N -> first wave_out rise in cycle N+DIV_W+1; a retune takes effect on a wave edge.
// Backpressure: freq_ready is low only while dividing. Optional edge_count port via FREQ_GEN_EDGE_COUNT_EN.
module freq_gen #(
    parameter int CLK_HZ = 50_000_000,
    parameter int FREQ_W = 20,
    parameter int DIV_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freq_valid,
    input  logic [FREQ_W-1:0] freq_hz,
    output logic              freq_ready,
    output logic              busy,
    output logic              active,
    output logic              wave_out,
    output logic              edge_pulse
`ifdef FREQ_GEN_EDGE_COUNT_EN
    ,
    output logic [31:0]       edge_count
`endif
);

    localparam int STEP_W = $clog2(DIV_W);
    localparam logic [DIV_W-1:0] CLK_DIV  = DIV_W'(CLK_HZ);
    localparam logic [DIV_W-1:0] HALF_CLK = DIV_W'(CLK_HZ / 2);

    typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_RUN} state_t;

    state_t state_q, state_d;

    logic              accept;
    logic              last_step;
    logic              wave_running;
    logic              hit;
    logic              stop;
    logic              rise;

    logic [DIV_W-1:0]  freq_ext;
    logic [DIV_W-1:0]  freq_clamped;
    logic [DIV_W-1:0]  divisor_new;

    logic [DIV_W-1:0]  divisor_q;
    logic [DIV_W-1:0]  dvd_q;
    logic [DIV_W-1:0]  rem_q;
    logic [DIV_W-1:0]  quo_q;
    logic [STEP_W-1:0] step_q;
    logic              from_run_q;

    logic [DIV_W:0]    rem_shift;
    logic              ge;
    logic [DIV_W-1:0]  rem_next;
    logic [DIV_W-1:0]  quo_next;
    logic [DIV_W-1:0]  half_new;

    logic [DIV_W-1:0]  half_period;
    logic [DIV_W-1:0]  counter;
    logic [DIV_W-1:0]  shadow_q;
    logic              pending_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        freq_ready = (state_q != S_DIVIDE);
        busy       = (state_q == S_DIVIDE);
        active     = (state_q == S_RUN);
        accept     = freq_valid && freq_ready;
        last_step  = (state_q == S_DIVIDE) && (step_q == STEP_W'(DIV_W - 1));
        case (state_q)
            S_IDLE:   if (accept && freq_hz != '0) state_d = S_DIVIDE;
            S_DIVIDE: if (last_step) state_d = S_RUN;
            S_RUN:    if (accept) state_d = (freq_hz == '0) ? S_IDLE : S_DIVIDE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Divisor is 2*min(freq_hz, CLK_HZ/2); divider steps one quotient bit per cycle.
    always_comb begin
        freq_ext     = DIV_W'(freq_hz);
        freq_clamped = (freq_ext > HALF_CLK) ? HALF_CLK : freq_ext;
        divisor_new  = freq_clamped << 1;
        rem_shift    = {rem_q, dvd_q[DIV_W-1]};
        ge           = (rem_shift >= {1'b0, divisor_q});
        rem_next     = ge ? DIV_W'(rem_shift - {1'b0, divisor_q}) : rem_shift[DIV_W-1:0];
        quo_next     = (quo_q << 1) | DIV_W'(ge);
        half_new     = (quo_next == '0) ? DIV_W'(1) : quo_next;
    end

    // The old waveform keeps running while a retune divide is in flight.
    always_comb begin
        wave_running = (state_q == S_RUN) || ((state_q == S_DIVIDE) && from_run_q);
        hit          = (counter == half_period - DIV_W'(1));
        stop         = accept && (freq_hz == '0) && (state_q == S_RUN);
        rise         = (wave_running && hit && !wave_out && !stop) ||
                       (last_step && !from_run_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            divisor_q   <= '0;
            dvd_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            step_q      <= '0;
            from_run_q  <= 1'b0;
            half_period <= '0;
            counter     <= '0;
            shadow_q    <= '0;
            pending_q   <= 1'b0;
            wave_out    <= 1'b0;
            edge_pulse  <= 1'b0;
        end else begin
            edge_pulse <= rise;

            if (wave_running) begin
                if (hit) begin
                    counter  <= '0;
                    wave_out <= ~wave_out;
                    if (pending_q) begin
                        half_period <= shadow_q;
                        pending_q   <= 1'b0;
                    end
                end else begin
                    counter <= counter + DIV_W'(1);
                end
            end

            if (accept && freq_hz != '0) begin
                divisor_q  <= divisor_new;
                dvd_q      <= CLK_DIV;
                rem_q      <= '0;
                quo_q      <= '0;
                step_q     <= '0;
                from_run_q <= (state_q == S_RUN);
            end

            if (stop) begin
                wave_out  <= 1'b0;
                counter   <= '0;
                pending_q <= 1'b0;
            end

            if (state_q == S_DIVIDE) begin
                rem_q  <= rem_next;
                quo_q  <= quo_next;
                dvd_q  <= dvd_q << 1;
                step_q <= step_q + STEP_W'(1);
                if (last_step) begin
                    // A completed retune overrides any older pending value.
                    if (from_run_q) begin
                        shadow_q  <= half_new;
                        pending_q <= 1'b1;
                    end else begin
                        half_period <= half_new;
                        counter     <= '0;
                        wave_out    <= 1'b1;
                        pending_q   <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef FREQ_GEN_EDGE_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst || accept)                        edge_count <= '0;
        else if (rise && edge_count != '1)        edge_count <= edge_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_freq_gen.sv
// Randomized self-checking bench for freq_gen against an arithmetic waveform model.
module tb_freq_gen;

    localparam int CLK_HZ = 50_000_000;
    localparam int FW     = 25;
    localparam int DW     = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          freq_valid = 1'b0;
    logic [FW-1:0] freq_hz = '0;
    logic          freq_ready, busy, active, wave_out, edge_pulse;
`ifdef FREQ_GEN_EDGE_COUNT_EN
    logic [31:0]   edge_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    freq_gen #(.CLK_HZ(CLK_HZ), .FREQ_W(FW), .DIV_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .freq_valid (freq_valid),
        .freq_hz    (freq_hz),
        .freq_ready (freq_ready),
        .busy       (busy),
        .active     (active),
        .wave_out   (wave_out),
        .edge_pulse (edge_pulse)
`ifdef FREQ_GEN_EDGE_COUNT_EN
        ,
        .edge_count (edge_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic int exp_half(input int f);
        int fc, h;
        fc = (f > CLK_HZ / 2) ? CLK_HZ / 2 : f;
        h  = CLK_HZ / (2 * fc);
        if (h == 0) h = 1;
        return h;
    endfunction

    function automatic logic wave_at(input int t, input int h);
        return ((t / h) % 2) == 0;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        freq_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic start_run(input int f);
        freq_valid = 1'b1;
        freq_hz    = FW'(f);
        tick();
        freq_valid = 1'b0;
        repeat (32) tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        freq_valid = 1'b1;
        freq_hz = FW'(1000);
        tick();
        n_checks++;
        if ({wave_out, edge_pulse, busy, active, freq_ready} !== 5'b00001)
            $display("FAIL reset_outputs got=%b exp=00001", {wave_out, edge_pulse, busy, active, freq_ready});
        else n_pass++;
        n_checks++;
        if (dut.half_period !== 32'd0 || dut.counter !== 32'd0)
            $display("FAIL reset_regs half=%0d cnt=%0d exp=0/0", dut.half_period, dut.counter);
        else n_pass++;
        rst = 1'b0;
        freq_valid = 1'b0;
    endtask

    task automatic test_basic;
        int flist[7];
        int h, len, exp_cnt;
        logic ew, ee;
        flist = '{1000, 3, 1_000_000, 0, 0, 0, 20_000_000};
        for (int k = 3; k < 6; k++) flist[k] = $urandom_range(6_000_000, 500_000);
        for (int k = 0; k < 7; k++) begin
            do_reset();
            freq_valid = 1'b1;
            freq_hz    = FW'(flist[k]);
            tick();
            freq_valid = 1'b0;
            for (int i = 0; i < 32; i++) begin
                n_checks++;
                if ({busy, freq_ready, active, wave_out} !== 4'b1000)
                    $display("FAIL basic_divide f=%0d i=%0d got=%b exp=1000", flist[k], i, {busy, freq_ready, active, wave_out});
                else n_pass++;
                tick();
            end
            h = exp_half(flist[k]);
            n_checks++;
            if (dut.half_period !== DW'(h))
                $display("FAIL basic_half f=%0d got=%0d exp=%0d", flist[k], dut.half_period, h);
            else n_pass++;
            len = (h > 30000) ? 300 : ((h > 100) ? h + 2 : 6 * h);
            exp_cnt = 0;
            for (int t = 0; t < len; t++) begin
                ew = wave_at(t, h);
                ee = (t % (2 * h)) == 0;
                exp_cnt += int'(ee);
                n_checks++;
                if ({wave_out, edge_pulse, active, busy} !== {ew, ee, 1'b1, 1'b0})
                    $display("FAIL basic_wave f=%0d t=%0d got=%b exp=%b", flist[k], t, {wave_out, edge_pulse, active, busy}, {ew, ee, 1'b1, 1'b0});
                else n_pass++;
`ifdef FREQ_GEN_EDGE_COUNT_EN
                n_checks++;
                if (edge_count !== 32'(exp_cnt))
                    $display("FAIL basic_edge_count t=%0d got=%0d exp=%0d", t, edge_count, exp_cnt);
                else n_pass++;
`endif
                tick();
            end
        end
    endtask

    task automatic test_clamp;
        int flist[3];
        logic ew;
        flist = '{30_000_000, 25_000_001, 0};
        flist[2] = $urandom_range(33_554_431, 25_000_001);
        for (int k = 0; k < 3; k++) begin
            do_reset();
            start_run(flist[k]);
            for (int t = 0; t < 10; t++) begin
                ew = (t % 2) == 0;
                n_checks++;
                if ({wave_out, edge_pulse} !== {ew, ew})
                    $display("FAIL clamp_wave f=%0d t=%0d got=%b exp=%b", flist[k], t, {wave_out, edge_pulse}, {ew, ew});
                else n_pass++;
                tick();
            end
        end
    endtask

    task automatic test_retune;
        int f1, f2, h1, h2, a, tb, len;
        logic ew, ee, eb, prev;
        for (int k = 0; k < 4; k++) begin
            f1 = $urandom_range(3_000_000, 1_000_000);
            f2 = $urandom_range(3_000_000, 1_000_000);
            h1 = exp_half(f1);
            h2 = exp_half(f2);
            a  = $urandom_range(40, 0);
            tb = ((a + 34 + h1 - 1) / h1) * h1;
            len = tb + 4 * h2 + 3;
            do_reset();
            start_run(f1);
            prev = 1'b0;
            for (int t = 0; t < len; t++) begin
                ew = (t < tb) ? wave_at(t, h1) : (wave_at(tb, h1) ^ (((t - tb) / h2) % 2 == 1));
                ee = ew && !prev;
                eb = (t > a) && (t <= a + 32);
                n_checks++;
                if ({wave_out, edge_pulse, busy, freq_ready} !== {ew, ee, eb, !eb})
                    $display("FAIL retune t=%0d a=%0d h1=%0d h2=%0d got=%b exp=%b", t, a, h1, h2, {wave_out, edge_pulse, busy, freq_ready}, {ew, ee, eb, !eb});
                else n_pass++;
                prev = ew;
                if (t == a) begin
                    freq_valid = 1'b1;
                    freq_hz    = FW'(f2);
                end else if (eb) begin
                    freq_valid = 1'($urandom_range(1, 0));
                    freq_hz    = FW'($urandom_range(5_000_000, 0));
                end else begin
                    freq_valid = 1'b0;
                end
                tick();
            end
        end
    endtask

    task automatic test_stop;
        do_reset();
        start_run($urandom_range(3_000_000, 1_000_000));
        repeat ($urandom_range(30, 1)) tick();
        n_checks++;
        if (active !== 1'b1) $display("FAIL stop_pre_active got=%b exp=1", active);
        else n_pass++;
        freq_valid = 1'b1;
        freq_hz    = '0;
        tick();
        freq_valid = 1'b0;
        n_checks++;
        if ({active, wave_out, edge_pulse, busy, freq_ready} !== 5'b00001)
            $display("FAIL stop_run got=%b exp=00001", {active, wave_out, edge_pulse, busy, freq_ready});
        else n_pass++;
        repeat (5) tick();
        n_checks++;
        if ({active, wave_out} !== 2'b00) $display("FAIL stop_hold got=%b exp=00", {active, wave_out});
        else n_pass++;
        freq_valid = 1'b1;
        tick();
        freq_valid = 1'b0;
        tick();
        n_checks++;
        if ({active, wave_out, busy, freq_ready} !== 4'b0001)
            $display("FAIL stop_idle_zero got=%b exp=0001", {active, wave_out, busy, freq_ready});
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            if (k == 0) begin
                freq_valid = 1'b1;
                freq_hz    = FW'(2_000_000);
                tick();
                freq_valid = 1'b0;
                repeat ($urandom_range(20, 2)) tick();
                n_checks++;
                if (busy !== 1'b1) $display("FAIL mid_pre_busy got=%b exp=1", busy);
                else n_pass++;
            end else begin
                start_run(2_000_000);
                repeat ($urandom_range(40, 2)) tick();
                n_checks++;
                if (active !== 1'b1) $display("FAIL mid_pre_active got=%b exp=1", active);
                else n_pass++;
            end
            rst        = 1'b1;
            freq_valid = 1'b1;
            freq_hz    = FW'($urandom_range(5_000_000, 1));
            tick();
            rst        = 1'b0;
            freq_valid = 1'b0;
            n_checks++;
            if ({wave_out, edge_pulse, busy, active, freq_ready} !== 5'b00001)
                $display("FAIL mid_reset k=%0d got=%b exp=00001", k, {wave_out, edge_pulse, busy, active, freq_ready});
            else n_pass++;
            n_checks++;
            if (dut.half_period !== 32'd0 || dut.counter !== 32'd0)
                $display("FAIL mid_reset_regs k=%0d half=%0d cnt=%0d exp=0/0", k, dut.half_period, dut.counter);
            else n_pass++;
`ifdef FREQ_GEN_EDGE_COUNT_EN
            n_checks++;
            if (edge_count !== 32'd0) $display("FAIL mid_edge_count got=%0d exp=0", edge_count);
            else n_pass++;
`endif
            tick();
            n_checks++;
            if (busy !== 1'b0) $display("FAIL mid_dropped k=%0d busy got=%b exp=0", k, busy);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_retune();
        test_stop();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/freq_gen.md
Name: freq_gen

Overview:
- Programmable square-wave generator; the transmit-side counterpart of the board's frequency meter.
- Takes a target frequency in Hz and produces a 50 % duty square wave on `wave_out`, derived from the 50 MHz system clock.
- Half-period is computed on-chip with a sequential restoring divider.
- Output can be looped back into the meter for self-test.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz (dividend of the divider).
- FREQ_W, 20, width of the requested frequency (max 999_999 Hz, six display digits).
- DIV_W, 32, divider and period-counter width; divide takes exactly DIV_W cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- freq_valid  in  1  request strobe; command accepted when freq_valid && freq_ready
- freq_hz  in  FREQ_W  requested frequency in Hz, sampled on accept
- freq_ready  out  1  high in IDLE and RUN, low in DIVIDE
- busy  out  1  high while in DIVIDE
- active  out  1  high while in RUN
- wave_out  out  1  generated square wave
- edge_pulse  out  1  one-cycle pulse in the cycle wave_out goes 0->1

Behaviour:
- Everything is synchronous to posedge clk. rst is synchronous, active-high.
- Reset values: state=IDLE, wave_out=0, edge_pulse=0, busy=0, active=0, freq_ready=1, half_period=0, counter=0.
- States are IDLE, DIVIDE and RUN.
- IDLE: wave_out held 0. On accept:
  - freq_hz==0: stay IDLE.
  - Otherwise: latch the request and go to DIVIDE.
- Divisor and clamp:
  - Divisor = 2*freq_hz, FREQ_W+1 bits, zero-extended to DIV_W.
  - If freq_hz > CLK_HZ/2, clamp freq_hz to CLK_HZ/2 before forming the divisor.
- DIVIDE:
  - Restoring division of CLK_HZ by the divisor, one quotient bit per cycle, MSB first.
  - Lasts exactly DIV_W cycles.
  - half_new = floor(CLK_HZ/divisor); if the result is 0, force half_new to 1.
  - freq_valid is ignored (freq_ready=0).
- DIVIDE -> RUN, entered from IDLE:
  - In the cycle after the last divide step: half_period=half_new, counter=0, wave_out=1, edge_pulse=1.
  - Latency from the accept cycle N to the first wave_out rise is N+DIV_W+1.
- DIVIDE, entered from RUN:
  - The waveform keeps running with the old half_period throughout DIVIDE.
  - On completion, half_new goes into a shadow register with a pending flag and the FSM returns to RUN.
- RUN:
  - counter increments each cycle.
  - When counter==half_period-1: counter<=0 and wave_out toggles.
  - If pending is set at that toggle, half_period<=shadow and pending is cleared, so the change is glitch-free on a wave edge.
  - edge_pulse is asserted on every 0->1 toggle.
- RUN accept:
  - freq_hz==0: go to IDLE next cycle; wave_out<=0, counter<=0, pending cleared.
  - Otherwise: go to DIVIDE (the old wave continues).
- Output period is 2*half_period clocks. Integer truncation error is accepted.
- Simultaneous rst and freq_valid: rst wins and the command is dropped.
- rst in any state (including mid-DIVIDE or mid-RUN) returns all outputs to their reset values on the next edge.
- counter never exceeds half_period-1. No wrap beyond DIV_W is possible because half_period <= CLK_HZ/2.

Optional Feature:
- Macro: FREQ_GEN_EDGE_COUNT_EN.
- When defined, an extra port is present: edge_count  out  32  number of wave_out rising edges since the last accepted command.
  - Clears on rst and on every accept.
  - Saturates at 0xFFFF_FFFF.
  - Increments in the same cycle edge_pulse is high.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- rst, then accept freq_hz=1000 -> busy for 32 cycles, then wave_out=1; it toggles every 25_000 cycles (period 50_000); edge_pulse every 50_000 cycles.
- freq_hz=3 -> half_period=8_333_333; wave_out high for exactly 8_333_333 cycles, then low for 8_333_333.
- freq_hz=30_000_000 (above CLK_HZ/2) -> clamped, half_period=1; wave_out toggles every cycle and edge_pulse is high every other cycle.
- Handshake and retune:
  - RUN at 1000 Hz; accept 2000 Hz -> freq_ready low 32 cycles.
  - The old 25_000 half-period continues; the first toggle after divide completes still uses 25_000.
  - Subsequent halves are 12_500.
  - freq_valid pulsed during DIVIDE is ignored.
- RUN at any frequency; accept freq_hz=0 -> next cycle active=0 and wave_out=0; freq_hz=0 while in IDLE leaves the FSM in IDLE.
- rst asserted mid-DIVIDE and mid-RUN (same cycle as freq_valid) -> next cycle all outputs at reset values. With FREQ_GEN_EDGE_COUNT_EN, edge_count=0, and after 10 periods at 1000 Hz edge_count=10.
